// File: rtl/mesi_isc_breq_arb.sv
// mesi_isc_breq_arb: round-robin arbiter feeding CPU broadcast requests into the broadcast FIFO
module mesi_isc_breq_arb #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    req_valid_array_i,
  input  logic [4*BROAD_TYPE_WIDTH-1:0] req_type_array_i,
  input  logic [4*ADDR_WIDTH-1:0]       req_addr_array_i,
  input  logic                          fifo_status_full_i,
  output logic [3:0]                    req_ack_array_o,
  output logic                          broad_fifo_wr_o,
  output logic [ADDR_WIDTH-1:0]         broad_addr_o,
  output logic [BROAD_TYPE_WIDTH-1:0]   broad_type_o,
  output logic [1:0]                    broad_cpu_id_o,
  output logic [BROAD_ID_WIDTH-1:0]     broad_id_o
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                      r_state, w_next;
  logic [1:0]                  r_rr_ptr, r_cpu_id, w_win;
  logic [BROAD_ID_WIDTH-1:0]   r_id_cnt, r_id;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [BROAD_TYPE_WIDTH-1:0] r_type;
  logic                        w_grant;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    w_win = r_rr_ptr;
    for (int k = 3; k >= 0; k--)
      if (req_valid_array_i[r_rr_ptr + 2'(k)]) w_win = r_rr_ptr + 2'(k);
    w_grant = (r_state == IDLE) && |req_valid_array_i && !fifo_status_full_i;
    w_next  = w_grant ? ISSUE : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rr_ptr <= '0;
      r_id_cnt <= '0;
      r_cpu_id <= '0;
      r_id     <= '0;
      r_addr   <= '0;
      r_type   <= '0;
    end else if (w_grant) begin
      r_addr   <= req_addr_array_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_type   <= req_type_array_i[w_win*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
      r_cpu_id <= w_win;
      r_id     <= r_id_cnt;
    end else if (r_state == ISSUE) begin
      r_rr_ptr <= r_cpu_id + 2'd1;
      r_id_cnt <= r_id_cnt + 1'b1;
    end
  // strobes decode straight from the state register so reset drops them at once
  assign broad_fifo_wr_o = (r_state == ISSUE);
  assign req_ack_array_o = {3'b000, broad_fifo_wr_o} << r_cpu_id;
  assign broad_addr_o    = r_addr;
  assign broad_type_o    = r_type;
  assign broad_cpu_id_o  = r_cpu_id;
  assign broad_id_o      = r_id;
endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// tb_mesi_isc_breq_arb: randomized scoreboard bench with a queue-based reference model
module tb_mesi_isc_breq_arb;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   valid = '0;
  logic [7:0]   typ = '0;
  logic [127:0] addr = '0;
  logic         full = 1'b0;
  logic [3:0]   ack;
  logic         wr;
  logic [31:0]  b_addr;
  logic [1:0]   b_type;
  logic [1:0]   b_cpu;
  logic [4:0]   b_id;

  mesi_isc_breq_arb dut (
    .clk(clk), .rst(rst),
    .req_valid_array_i(valid), .req_type_array_i(typ), .req_addr_array_i(addr),
    .fifo_status_full_i(full),
    .req_ack_array_o(ack), .broad_fifo_wr_o(wr), .broad_addr_o(b_addr),
    .broad_type_o(b_type), .broad_cpu_id_o(b_cpu), .broad_id_o(b_id)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [1:0] t; int cpu; int id;} exp_t;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: a grant happens whenever the arbiter is free, something is valid and
  // the FIFO has room; the winner is the nearest valid CPU at or after the pointer
  int m_rr = 0, m_id = 0;
  bit m_busy = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rr = 0; m_id = 0; m_busy = 0; q.delete();
    end else if (m_busy) m_busy = 0;
    else if (valid != 0 && !full) begin
      int w;
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && valid[(m_rr + k) % 4]) w = (m_rr + k) % 4;
      q.push_back('{addr[w*32 +: 32], typ[w*2 +: 2], w, m_id});
      m_id = (m_id + 1) % 32;
      m_rr = (w + 1) % 4;
      m_busy = 1;
    end
  end

  always @(negedge clk) if (rst) begin
    if (wr) begin
      if (q.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
      else begin
        exp_t e;
        e = q.pop_front();
        chk("addr", 64'(b_addr), 64'(e.a));
        chk("type", 64'(b_type), 64'(e.t));
        chk("cpu_id", 64'(b_cpu), 64'(e.cpu));
        chk("id", 64'(b_id), 64'(e.id));
        chk("ack", 64'(ack), 64'(4'b0001 << e.cpu));
      end
    end else begin
      chk("ack_idle", 64'(ack), 64'(0));
      chk("missed_write", 64'(q.size()), 64'(0));
      q.delete();
    end
  end

  task automatic new_req(input int c);
    addr[c*32 +: 32] = $urandom;
    typ[c*2 +: 2]    = 2'($urandom_range(3));
  endtask

  // one clock of requester behaviour; inputs change 1 time unit after the edge
  task automatic step();
    logic [3:0] a;
    @(negedge clk);
    a = ack;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (valid[c] && a[c]) begin
        if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) new_req(c);
        else valid[c] = 1'b0;
      end else if (!valid[c] && (mode == 1 || (mode == 2 && $urandom_range(3) == 0))) begin
        valid[c] = 1'b1;
        new_req(c);
      end
    if (mode == 2) full = ($urandom_range(9) < 3);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    chk("rst_wr", 64'(wr), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_addr", 64'(b_addr), 64'(0));
    chk("rst_type", 64'(b_type), 64'(0));
    chk("rst_cpu", 64'(b_cpu), 64'(0));
    chk("rst_id", 64'(b_id), 64'(0));
    #1 rst = 1'b1;
    valid = 4'b0100; addr[64 +: 32] = 32'h0000_1040; typ[4 +: 2] = 2'b01;
    repeat (6) step();
    full = 1'b1; valid[1] = 1'b1; addr[32 +: 32] = 32'hCAFE_0010; typ[2 +: 2] = 2'b11;
    repeat (5) step();
    full = 1'b0;
    repeat (5) step();
    mode = 1;
    repeat (80) step();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = wr;
    end
    chk("issue_seen_before_reset", 64'(seen), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_wr", 64'(wr), 64'(0));
    chk("async_rst_ack", 64'(ack), 64'(0));
    repeat (2) step();
    rst = 1'b1;
    repeat (20) step();
    mode = 2;
    repeat (2000) step();
    mode = 0;
    valid = '0; full = 1'b0;
    repeat (4) step();
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mesi_isc_breq_arb.md
Name: mesi_isc_breq_arb

Overview:
- Upstream feeder of the MESI ISC broadcast stage.
- Collects broadcast requests from the 4 CPU main-bus ports and arbitrates among them round-robin.
- Tags each winner with a sequential broadcast ID and writes one entry per grant into the broadcast request FIFO: broad_fifo_wr/addr/type/cpu_id/id.
- Respects FIFO full backpressure and returns a one-cycle ack to the winning CPU.

Parameters:
- ADDR_WIDTH, 32, request/broadcast address width.
- BROAD_TYPE_WIDTH, 2, broadcast type field width.
- BROAD_ID_WIDTH, 5, broadcast ID width; the ID counter wraps modulo 2^BROAD_ID_WIDTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset); assertion is asynchronous.
- req_valid_array_i  input  4  bit n = CPU n has a broadcast request pending.
- req_type_array_i  input  4*BROAD_TYPE_WIDTH  CPU n type at bits [n*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH].
- req_addr_array_i  input  4*ADDR_WIDTH  CPU n address at bits [n*ADDR_WIDTH +: ADDR_WIDTH].
- fifo_status_full_i  input  1  broadcast FIFO full; no write is allowed while it is 1.
- req_ack_array_o  output  4  one-hot; pulses for one cycle when CPU n's request is written.
- broad_fifo_wr_o  output  1  write strobe to the broadcast FIFO.
- broad_addr_o  output  ADDR_WIDTH  address of the written entry.
- broad_type_o  output  BROAD_TYPE_WIDTH  type of the written entry.
- broad_cpu_id_o  output  2  originating CPU index.
- broad_id_o  output  BROAD_ID_WIDTH  broadcast ID of the written entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, id_cnt=0.
  - All outputs 0: broad_fifo_wr_o, req_ack_array_o, addr/type/cpu_id/id.
- FSM states: IDLE, ISSUE.
- IDLE, grant condition: |req_valid_array_i and fifo_status_full_i==0.
  - Winner = first set valid bit scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Capture winner's addr/type, its index and id_cnt into the output registers.
  - Go to ISSUE.
  - If no valid request or FIFO full: stay in IDLE; outputs remain 0 or stable, with wr and ack equal to 0.
- ISSUE (exactly 1 cycle):
  - broad_fifo_wr_o=1 and req_ack_array_o[winner]=1, both driven from registers.
  - Next state IDLE; rr_ptr <= winner+1 mod 4; id_cnt <= id_cnt+1 (wraps 31->0 at default width).
  - broad_fifo_wr_o and req_ack_array_o return to 0 in the next cycle.
- Latency: 1 cycle from grant decision to FIFO write. Throughput: at most 1 write per 2 cycles.
- Data outputs hold their last written values between writes. Only broad_fifo_wr_o qualifies them.
- Requester rule:
  - Valid and addr/type are held until ack.
  - A requester may deassert valid in the cycle after ack, or keep it high to post a new request.
  - That new request is considered at the next IDLE.
  - The block ignores valid in ISSUE, so one request is never granted twice.
- Full handling:
  - Full is sampled only at grant. The downstream FIFO only drains between grant and write, so the ISSUE write is always legal.
  - fifo_status_full_i rising during ISSUE does not cancel the write.
- Requests withdrawn before grant are not granted. Withdrawal after grant is illegal, but the captured values are still written.
- Reset mid-ISSUE: wr and ack drop immediately (asynchronously). The entry is lost, and the ID counter and rr_ptr restart at 0.
- Fairness: every continuously valid CPU is granted within 4 grants.

Test Plan:
- Reset, then CPU2 valid with addr 0x0000_1040, type 2'b01, full=0 -> write 2 cycles after valid: addr=0x1040, type=01, cpu_id=2, id=0, ack=4'b0100 for one cycle.
- All 4 valid continuously from reset -> writes with cpu_id 0,1,2,3,0, ids 0..4, one write every 2 cycles, each ack matching its cpu_id.
- CPU1 valid with full=1 for 5 cycles, then full=0 -> no wr/ack while full; write with cpu_id=1 two cycles after full drops.
- 33 single-CPU grants -> broad_id sequence 0..31, then 0 (wrap).
- full rises in the ISSUE cycle -> write and ack still occur that cycle; no further grant while full=1.
- rst=0 asserted mid-ISSUE -> broad_fifo_wr_o and ack go to 0 before the next edge; the next write after reset has id=0, and scanning restarts at CPU0.
